// File: rtl/seq_div_sign.sv
// seq_div_sign: iterative restoring divider, one quotient bit per clock, signed or unsigned operands.
// Define SEQ_DIV_OVF_EN to add the ovf output (signed -2^(La-1) / -1 overflow flag).
module seq_div_sign #(
  parameter int La = 8,
  parameter int Lb = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [La-1:0] A,
  input  logic [Lb-1:0] B,
  input  logic          sg,
  output logic          busy,
  output logic          done,
  output logic [La-1:0] Q,
  output logic [Lb-1:0] R,
  output logic          dz,
`ifdef SEQ_DIV_OVF_EN
  output logic          ovf,
`endif
  output logic [1:0]    o_dbg_state
);

  // Handshake: start is sampled only in IDLE; busy covers CALC, FIX and DONE;
  // done pulses for one cycle with Q/R/dz valid, and those hold until the next result.

  localparam int CW = $clog2(La + 1);
  localparam logic [CW-1:0] LAST = CW'(La);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [La-1:0] r_a;
  logic [Lb-1:0] r_b;
  logic [Lb-1:0] r_p;
  logic          r_sa;
  logic          r_sb;
  logic          r_bz;
  logic [La-1:0] r_q;
  logic [Lb-1:0] r_r;
  logic          r_dz;

  logic [Lb:0]   w_p_sh;
  logic          w_ge;
  logic [Lb-1:0] w_p_sub;
  logic [La-1:0] w_q_fix;
  logic [Lb-1:0] w_r_fix;

`ifdef SEQ_DIV_OVF_EN
  logic r_ovf_pend;
  logic r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // The remainder after a subtract is below |B|, so Lb bits of P are enough to keep.
  assign w_p_sh  = {r_p, r_a[La-1]};
  assign w_ge    = (w_p_sh >= {1'b0, r_b});
  assign w_p_sub = w_p_sh[Lb-1:0] - r_b;
  assign w_q_fix = (r_sa ^ r_sb) ? -r_a : r_a;
  assign w_r_fix = r_sa ? -r_p : r_p;

  // First CALC cycle turns the latched operands into magnitudes; the next La retire quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_p   <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_bz  <= 1'b0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
`ifdef SEQ_DIV_OVF_EN
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_sa  <= sg & A[La-1];
            r_sb  <= sg & B[Lb-1];
            r_cnt <= '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '0) begin
            r_a  <= r_sa ? -r_a : r_a;
            r_b  <= r_sb ? -r_b : r_b;
            r_p  <= '0;
            r_bz <= (r_b == '0);
`ifdef SEQ_DIV_OVF_EN
            r_ovf_pend <= r_sa & r_sb & (r_a == {1'b1, {(La-1){1'b0}}}) & (r_b == '1);
`endif
          end else begin
            r_p <= w_ge ? w_p_sub : w_p_sh[Lb-1:0];
            r_a <= {r_a[La-2:0], w_ge};
          end
        end
        S_FIX: begin
          if (r_bz) begin
            r_q  <= '1;
            r_r  <= '0;
            r_dz <= 1'b1;
          end else begin
            r_q  <= w_q_fix;
            r_r  <= w_r_fix;
            r_dz <= 1'b0;
          end
`ifdef SEQ_DIV_OVF_EN
          r_ovf <= r_ovf_pend & ~r_bz;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign Q           = r_q;
  assign R           = r_r;
  assign dz          = r_dz;
  assign o_dbg_state = r_state;
`ifdef SEQ_DIV_OVF_EN
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_seq_div_sign.sv
// tb_seq_div_sign: scoreboard bench for seq_div_sign (La=8, Lb=4); expected results come from an integer model.
// Build with +define+SEQ_DIV_OVF_EN to also cover the ovf output.
module tb_seq_div_sign;
  localparam int La  = 8;
  localparam int Lb  = 4;
  localparam int W   = La + Lb + 2;
  localparam int LAT = La + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sg    = 1'b0;
  logic [La-1:0] A     = '0;
  logic [Lb-1:0] B     = '0;
  logic          busy;
  logic          done;
  logic [La-1:0] Q;
  logic [Lb-1:0] R;
  logic          dz;
  logic [1:0]    dbg_state;
  logic          obs_ovf;
  logic [W-1:0]  obs;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

`ifdef SEQ_DIV_OVF_EN
  logic ovf;
  assign obs_ovf = ovf;
`else
  assign obs_ovf = 1'b0;
`endif
  assign obs = {obs_ovf, dz, R, Q};

  seq_div_sign #(.La(La), .Lb(Lb)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sg(sg),
    .busy(busy), .done(done), .Q(Q), .R(R), .dz(dz),
`ifdef SEQ_DIV_OVF_EN
    .ovf(ovf),
`endif
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Result packed as {ovf, dz, R, Q}.
  function automatic logic [W-1:0] model(input logic [La-1:0] a, input logic [Lb-1:0] b, input logic s);
    int ai, bi, qi, ri;
    logic [La-1:0] q;
    logic [Lb-1:0] r;
    logic o;
    o = 1'b0;
    if (b == '0) return {1'b0, 1'b1, {Lb{1'b0}}, {La{1'b1}}};
    if (s) begin
      ai = $signed(a);
      bi = $signed(b);
    end else begin
      ai = int'(a);
      bi = int'(b);
    end
    qi = ai / bi;
    ri = ai % bi;
    q  = qi[La-1:0];
    r  = ri[Lb-1:0];
`ifdef SEQ_DIV_OVF_EN
    o = s && (a == {1'b1, {(La-1){1'b0}}}) && (b == '1);
`endif
    return {o, 1'b0, r, q};
  endfunction

  // Called at a falling edge; leaves start low one cycle after acceptance, with inputs scrambled.
  task automatic drive_op(input logic [La-1:0] a, input logic [Lb-1:0] b, input logic s);
    A = a; B = b; sg = s; start = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A  = La'($urandom);
    B  = Lb'($urandom);
    sg = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, obs, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h st=%0d want all zero", busy, done, obs, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [La-1:0] ta[4] = '{8'd200, 8'h80, 8'hFF, 8'd3};
    logic [Lb-1:0] tb[4] = '{4'd7, 4'h8, 4'hF, 4'd9};
    logic [W-1:0] e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_op(ta[i], tb[i], 1'b0);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_after_start: got %b want 1", busy);
      end
      wait_done(lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat != LAT) begin
        n_err++;
        $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, lat, LAT);
      end
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL unsigned_result[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 0) begin
        n_vec++;
        if (Q !== 8'h1C || R !== 4'd4 || dz !== 1'b0) begin
          n_err++;
          $display("FAIL unsigned_200_by_7: got Q=%h R=%h dz=%b want Q=1c R=4 dz=0", Q, R, dz);
        end
      end
    end
  endtask

  task automatic test_signed;
    logic [La-1:0] ta[6] = '{8'h9C, 8'd100, 8'h80, 8'h80, 8'h81, 8'h07};
    logic [Lb-1:0] tb[6] = '{4'd7, 4'h9, 4'h8, 4'h8, 4'h3, 4'hE};
    logic          ts[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_op(ta[i], tb[i], ts[i]);
      wait_done(lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat != LAT || obs !== e) begin
        n_err++;
        $display("FAIL signed_result[%0d]: got lat=%0d res=%h want lat=%0d res=%h", i, lat, obs, LAT, e);
      end
      if (i == 0) begin
        n_vec++;
        if (Q !== 8'hF2 || R !== 4'hE) begin
          n_err++;
          $display("FAIL signed_m100_by_7: got Q=%h R=%h want Q=f2 R=e", Q, R);
        end
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] e;
    int lat;
    @(negedge clk);
    drive_op(8'h55, 4'h0, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat != LAT || obs !== e || Q !== 8'hFF || dz !== 1'b1) begin
      n_err++;
      $display("FAIL div_zero_unsigned: got lat=%0d res=%h want lat=%0d res=%h", lat, obs, LAT, e);
    end
    @(negedge clk);
    drive_op(8'h80, 4'h0, 1'b1);
    wait_done(lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat != LAT || obs !== e) begin
      n_err++;
      $display("FAIL div_zero_signed: got lat=%0d res=%h want lat=%0d res=%h", lat, obs, LAT, e);
    end
    @(negedge clk);
    drive_op(8'd200, 4'd7, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    n_vec++;
    if (dz !== 1'b0 || obs !== e) begin
      n_err++;
      $display("FAIL dz_clears: got dz=%b res=%h want dz=0 res=%h", dz, obs, e);
    end
  endtask

  task automatic test_busy_ignore;
    logic [W-1:0] e;
    int lat;
    int n_done;
    @(negedge clk);
    A = 8'hC3; B = 4'h5; sg = 1'b1; start = 1'b1;
    exp_q.push_back(model(8'hC3, 4'h5, 1'b1));
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (done !== 1'b1 && lat < 40) begin
      A  = La'($urandom);
      B  = Lb'($urandom);
      sg = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (lat != LAT || obs !== e) begin
      n_err++;
      $display("FAIL busy_ignore_result: got lat=%0d res=%h want lat=%0d res=%h", lat, obs, LAT, e);
    end
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL start_in_done_ignored: got %0d busy/done cycles want 0", n_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive_op(La'($urandom), Lb'($urandom_range(15, 1)), 1'($urandom));
      wait_done(lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat != LAT || obs !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got lat=%0d res=%h want lat=%0d res=%h", i, lat, obs, LAT, e);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse_width[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    @(negedge clk);
    A = 8'd200; B = 4'd7; sg = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, obs, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_calc: got busy=%b done=%b res=%h st=%0d want all zero", busy, done, obs, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL reset_aborts: got %0d done pulses want 0", n_done);
    end
  endtask

`ifdef SEQ_DIV_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] e;
    int lat;
    @(negedge clk);
    drive_op(8'h80, 4'hF, 1'b1);
    wait_done(lat);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e || Q !== 8'h80 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_signed: got Q=%h ovf=%b res=%h want Q=80 ovf=1 res=%h", Q, ovf, obs, e);
    end
    @(negedge clk);
    drive_op(8'h80, 4'hF, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e || Q !== 8'd8 || R !== 4'd8 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_unsigned: got Q=%h R=%h ovf=%b want Q=08 R=8 ovf=0", Q, R, ovf);
    end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] e;
    int lat;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(3, 1)) @(negedge clk);
      drive_op(La'($urandom), Lb'($urandom), 1'($urandom));
      wait_done(lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat != LAT || obs !== e) begin
        n_err++;
        $display("FAIL random[%0d]: got lat=%0d res=%h want lat=%0d res=%h", i, lat, obs, LAT, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_DIV_OVF_EN
    test_ovf();
`endif
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
